trivium_xor_packer: RTL and testbench
=====================================

// Module: trivium_xor_packer
// PURPOSE
// - Downstream stage of the Trivium keystream generator.
// - Accepts keystream one bit per cycle and packs it LSB-first into DATA_W-bit key words.
// - XORs each key word with a plaintext word to produce a ciphertext word for a
//   programmed message length; the same datapath also decrypts.
// - Sits between the keystream generator and the byte-stream transport; all three
//   interfaces use valid/ready flow control.
// PARAMETERS
// DATA_W  8   plaintext/ciphertext word width; also keystream bits packed per word
// LEN_W   16  width of the message-length input, in words
// PORTS
// clk       in   1       clock, rising edge
// reset     in   1       asynchronous, active-low reset
// start     in   1       pulse: latch len and begin a message (ignored while busy)
// len       in   LEN_W   message length in words, sampled on an accepted start
// ks_valid  in   1       keystream bit valid
// ks_bit    in   1       keystream bit
// ks_ready  out  1       keystream bit accepted when ks_valid & ks_ready
// pt_valid  in   1       plaintext word valid
// pt_data   in   DATA_W  plaintext word
// pt_ready  out  1       plaintext word consumed when pt_valid & pt_ready
// ct_valid  out  1       ciphertext word valid
// ct_data   out  DATA_W  ciphertext word
// ct_ready  in   1       downstream accepts ciphertext
// busy      out  1       high from the cycle after an accepted start until done
// done      out  1       one-cycle pulse when the message is complete
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; kcnt=0, kword=0, rem=0.
//   Outputs ct_valid=0, ct_data=0, busy=0, done=0. ks_ready=0 and pt_ready=0 (combinational).
//   Reset mid-message aborts it; no partial output survives.
// - States: IDLE, RUN, FLUSH.
//   - IDLE: start=1 -> rem<=len.
//     - len!=0: go to RUN.
//     - len==0: done=1 next cycle, stay in IDLE, no ks/pt/ct handshake occurs.
//   - RUN: busy=1.
//     - ks_ready = (kcnt<DATA_W) & (rem!=0).
//     - Each accepted ks bit is written to kword[kcnt]; then kcnt++. The first bit goes to the LSB.
//     - combine = (kcnt==DATA_W) & pt_valid & (!ct_valid | ct_ready).
//     - pt_ready = combine (combinational).
//     - On combine: ct_data<=pt_data^kword, ct_valid<=1, kcnt<=0, rem<=rem-1.
//     - No ks bit is accepted in a combine cycle.
//     - When rem reaches 0 via combine -> FLUSH.
//   - FLUSH: wait for the final ct handshake. On ct_valid & ct_ready:
//     ct_valid<=0, done<=1 (one cycle), state<=IDLE.
// - ct_valid / ct_data:
//   - Cleared when ct_valid & ct_ready and no combine occurs that cycle.
//   - Held stable while ct_valid & !ct_ready.
//   - Overwritten only in a combine cycle, which requires the slot to be empty or draining
//     (back-to-back handshake allowed).
// - Keystream collection for the next word continues while the ct slot is stalled.
//   ks_ready drops once kcnt==DATA_W.
// - Latency: with continuous ks_valid/pt_valid/ct_ready, start at cycle 0:
//   - ks bits accepted in cycles 1..DATA_W;
//   - combine at cycle DATA_W+1;
//   - ct_valid at cycle DATA_W+2.
//   Throughput is one word per DATA_W+1 cycles.
// - Exactly DATA_W*len keystream bits are consumed per message; ks_ready never rises after rem==0.
// - start while busy is ignored; len changes while busy have no effect.
// - rem counts in LEN_W bits; len=2^LEN_W-1 is legal and does not wrap.
// TESTING
// - T1: len=1; ks bits 1,0,1,0,0,1,0,1 (kword=0xA5); pt=0xFF
//   -> ct_data=0x5A, ct_valid at cycle 10, done pulse the cycle after the ct handshake.
// - T2: len=0 start -> done=1 on the next cycle; ks_ready, pt_ready and ct_valid stay 0; busy stays 0.
// - T3: len=2; hold ct_ready=0 for 12 cycles after the first ct_valid
//   -> ct_data stable; exactly 8 further ks bits accepted, then ks_ready=0; no pt consumed.
//   Release -> second word correct.
// - T4: len=3; all-ones keystream, pt=0x00,0x0F,0xF0 -> ct=0xFF,0xF0,0x0F;
//   exactly 24 ks handshakes; one word per 9 cycles.
// - T5: len=2; drop reset after 4 ks bits -> all outputs 0 asynchronously.
//   Then restart with len=1 -> correct single word, with no stale key bits.
// - T6: start pulsed again with len=5 mid-message (len=2)
//   -> ignored; exactly 2 ct words and one done pulse.

Source files
------------

// File: rtl/trivium_xor_packer_if.sv
// Bundle of the control, keystream, plaintext and ciphertext handshake signals
// for trivium_xor_packer. The packer attaches through the slave modport and
// its environment (or a testbench) through the master modport.
interface trivium_xor_packer_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
);
    // message control
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    // keystream, one bit per transfer
    logic              ks_valid;
    logic              ks_bit;
    logic              ks_ready;
    // plaintext words in
    logic              pt_valid;
    logic [DATA_W-1:0] pt_data;
    logic              pt_ready;
    // ciphertext words out
    logic              ct_valid;
    logic [DATA_W-1:0] ct_data;
    logic              ct_ready;

    modport master (
        output start, len, ks_valid, ks_bit, pt_valid, pt_data, ct_ready,
        input  busy, done, ks_ready, pt_ready, ct_valid, ct_data
    );

    modport slave (
        input  start, len, ks_valid, ks_bit, pt_valid, pt_data, ct_ready,
        output busy, done, ks_ready, pt_ready, ct_valid, ct_data
    );
endinterface

// File: rtl/trivium_xor_packer.sv
// Packs a serial keystream LSB-first into DATA_W-bit key words and XORs each
// one with a plaintext word, producing len ciphertext words per message.
// Encryption and decryption use the same datapath.
module trivium_xor_packer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,   // asynchronous, active-low
    trivium_xor_packer_if.slave   bus
);
    // kcnt must be able to hold DATA_W itself ("key word full")
    localparam int KCNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [KCNT_W-1:0]   kcnt_q, kcnt_d;
    logic [DATA_W-1:0]   kword_q, kword_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                ct_valid_q, ct_valid_d;
    logic [DATA_W-1:0]   ct_data_q, ct_data_d;
    logic                done_q, done_d;

    logic                ks_ready_w;
    logic                ks_fire;
    logic                combine;

    // Handshake qualifiers: collect key bits until the word is full, and combine
    // once a full key word meets a plaintext word and the output slot is free
    // or draining this cycle.
    always_comb begin
        ks_ready_w = (state_q == S_RUN) && (kcnt_q < KCNT_W'(DATA_W)) && (rem_q != '0);
        ks_fire    = bus.ks_valid && ks_ready_w;
        combine    = (state_q == S_RUN) && (kcnt_q == KCNT_W'(DATA_W)) && bus.pt_valid
                     && (!ct_valid_q || bus.ct_ready);
    end

    // Each key bit lands at the position given by kcnt; bits already collected
    // are kept. A combine resets kcnt, so the next word overwrites every bit.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_kword
            assign kword_d[gi] = (ks_fire && (kcnt_q == KCNT_W'(gi))) ? bus.ks_bit
                                                                       : kword_q[gi];
        end
    endgenerate

    // Message sequencing, word counting and the single-entry ciphertext slot.
    always_comb begin
        state_d    = state_q;
        kcnt_d     = kcnt_q;
        rem_d      = rem_q;
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;
        done_d     = 1'b0;

        // a drained slot empties unless a combine refills it below
        if (ct_valid_q && bus.ct_ready) begin
            ct_valid_d = 1'b0;
            ct_data_d  = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rem_d  = bus.len;
                    kcnt_d = '0;
                    if (bus.len != '0) begin
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;   // empty message completes at once
                    end
                end
            end
            S_RUN: begin
                if (ks_fire) begin
                    kcnt_d = kcnt_q + KCNT_W'(1);
                end
                if (combine) begin
                    ct_valid_d = 1'b1;
                    ct_data_d  = bus.pt_data ^ kword_q;
                    kcnt_d     = '0;
                    rem_d      = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // last word is in the slot; finish when it is taken
                if (ct_valid_q && bus.ct_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any message in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            kcnt_q     <= '0;
            kword_q    <= '0;
            rem_q      <= '0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kcnt_q     <= kcnt_d;
            kword_q    <= kword_d;
            rem_q      <= rem_d;
            ct_valid_q <= ct_valid_d;
            ct_data_q  <= ct_data_d;
            done_q     <= done_d;
        end
    end

    assign bus.ks_ready = ks_ready_w;
    assign bus.pt_ready = combine;
    assign bus.ct_valid = ct_valid_q;
    assign bus.ct_data  = ct_data_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_trivium_xor_packer.sv
// Randomized bench for trivium_xor_packer. Keystream bits and plaintext words
// are prepared as streams up front; the reference ciphertext for word i is
// pt[i] XOR (keystream bits 8i..8i+7, first bit in the LSB).
module tb_trivium_xor_packer;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    trivium_xor_packer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    trivium_xor_packer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit               ks_q[$];
    logic [DATA_W-1:0] pt_q[$];
    logic [DATA_W-1:0] got_ct[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference key word i XOR plaintext word i
    function automatic logic [DATA_W-1:0] exp_word(input int i);
        logic [DATA_W-1:0] k;
        for (int j = 0; j < DATA_W; j++) k[j] = ks_q[DATA_W*i + j];
        return k ^ pt_q[i];
    endfunction

    task automatic fill_random(input int len);
        ks_q.delete();
        pt_q.delete();
        for (int i = 0; i < DATA_W*len + 2*DATA_W; i++) ks_q.push_back(bit'($urandom_range(0, 1)));
        for (int i = 0; i < len + 4; i++) pt_q.push_back(DATA_W'($urandom));
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.ks_valid = 1'b0;
        bus.ks_bit   = 1'b0;
        bus.pt_valid = 1'b0;
        bus.pt_data  = '0;
        bus.ct_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ct_valid"}, 32'(bus.ct_valid), 0);
        check_eq({tag, "_ct_data"},  32'(bus.ct_data),  0);
        check_eq({tag, "_busy"},     32'(bus.busy),     0);
        check_eq({tag, "_done"},     32'(bus.done),     0);
        check_eq({tag, "_ks_ready"}, 32'(bus.ks_ready), 0);
        check_eq({tag, "_pt_ready"}, 32'(bus.pt_ready), 0);
    endtask

    // One message: start in cycle 0, then drive/observe cycle by cycle.
    // stall>0 holds ct_ready low from the first ct_valid for that many cycles.
    // inject pulses start (len=5) in cycle 5. exp_first/exp_last: -1 = skip.
    task automatic run_msg(input string tag, input int len, input int p_ks, input int p_pt,
                           input int p_ct, input int stall, input bit inject,
                           input int exp_first, input int exp_last);
        int ks_idx = 0, pt_idx = 0, words = 0, done_cnt = 0;
        int done_cyc = -1, first_v = -1, last_hs = -1;
        int budget = 100 + 80*len;
        bit busy_seen = 1'b0, finished = 1'b0;
        logic [DATA_W-1:0] hold = '0;
        got_ct.delete();
        @(posedge clk); #1;
        idle_inputs();
        bus.start = 1'b1;
        bus.len   = LEN_W'(len);
        for (int c = 1; c <= budget && !finished; c++) begin
            @(posedge clk); #1;
            bus.start    = inject && (c == 5);
            bus.len      = (inject && c == 5) ? LEN_W'(5) : LEN_W'($urandom);
            bus.ks_valid = (ks_idx < ks_q.size()) && ($urandom_range(1, 100) <= p_ks);
            bus.ks_bit   = (ks_idx < ks_q.size()) ? ks_q[ks_idx] : 1'b0;
            bus.pt_valid = (pt_idx < pt_q.size()) && ($urandom_range(1, 100) <= p_pt);
            bus.pt_data  = (pt_idx < pt_q.size()) ? pt_q[pt_idx] : '0;
            bus.ct_ready = (stall > 0 && (first_v < 0 || c <= first_v + stall)) ? 1'b0
                           : ($urandom_range(1, 100) <= p_ct);
            @(negedge clk);
            if (bus.busy) busy_seen = 1'b1;
            if (c == 1 && len != 0) check_eq({tag, "_busy_after_start"}, 32'(bus.busy), 1);
            if (bus.ks_valid && bus.ks_ready) ks_idx++;
            if (bus.pt_valid && bus.pt_ready) pt_idx++;
            if (bus.ct_valid && first_v < 0) begin
                first_v = c;
                hold    = bus.ct_data;
            end
            if (stall > 0 && first_v > 0 && c > first_v && c <= first_v + stall) begin
                check_eq({tag, "_stall_valid"}, 32'(bus.ct_valid), 1);
                check_eq({tag, "_stall_data"},  32'(bus.ct_data), 32'(hold));
                if (c == first_v + stall) begin
                    check_eq({tag, "_stall_ks_cnt"},   ks_idx, 2*DATA_W);
                    check_eq({tag, "_stall_pt_cnt"},   pt_idx, 1);
                    check_eq({tag, "_stall_ks_ready"}, 32'(bus.ks_ready), 0);
                end
            end
            if (bus.ct_valid && bus.ct_ready) begin
                if (words < len) check_eq({tag, "_ct_word"}, 32'(bus.ct_data), 32'(exp_word(words)));
                $display("%s: ct word %0d = 0x%02h at cycle %0d", tag, words, bus.ct_data, c);
                got_ct.push_back(bus.ct_data);
                words++;
                last_hs = c;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) finished = 1'b1;
        end
        check_eq({tag, "_completed"}, 32'(finished), 1);
        check_eq({tag, "_words"},    words,    len);
        check_eq({tag, "_ks_count"}, ks_idx,   DATA_W*len);
        check_eq({tag, "_pt_count"}, pt_idx,   len);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        if (len == 0) begin
            check_eq({tag, "_done_cycle"}, done_cyc, 1);
            check_eq({tag, "_busy_seen"},  32'(busy_seen), 0);
            check_eq({tag, "_ct_seen"},    first_v, -1);
        end else begin
            check_eq({tag, "_done_after_hs"}, done_cyc, last_hs + 1);
            if (exp_first >= 0) check_eq({tag, "_first_valid_cycle"}, first_v, exp_first);
            if (exp_last >= 0)  check_eq({tag, "_last_hs_cycle"},      last_hs, exp_last);
        end
        idle_inputs();
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t4_exp[3];
        idle_inputs();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // T1: known key word 0xA5 against 0xFF
        ks_q = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 16; i++) ks_q.push_back(bit'($urandom_range(0, 1)));
        pt_q = '{8'hFF, 8'h00};
        run_msg("t1", 1, 100, 100, 100, 0, 1'b0, 10, 10);
        check_eq("t1_nwords", got_ct.size(), 1);
        if (got_ct.size() > 0) check_eq("t1_ct_5a", 32'(got_ct[0]), 32'h5A);

        // T2: empty message
        fill_random(0);
        run_msg("t2", 0, 100, 100, 100, 0, 1'b0, -1, -1);

        // T3: output stall while the next key word collects
        fill_random(2);
        run_msg("t3", 2, 100, 100, 100, 12, 1'b0, 10, -1);

        // T4: all-ones keystream, one word every 9 cycles
        ks_q.delete();
        for (int i = 0; i < 40; i++) ks_q.push_back(1'b1);
        pt_q = '{8'h00, 8'h0F, 8'hF0, 8'h55};
        run_msg("t4", 3, 100, 100, 100, 0, 1'b0, 10, 28);
        t4_exp = '{8'hFF, 8'hF0, 8'h0F};
        check_eq("t4_nwords", got_ct.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got_ct.size()) check_eq("t4_ct_const", 32'(got_ct[i]), 32'(t4_exp[i]));

        // T5: asynchronous reset after 4 key bits, then a clean message
        fill_random(2);
        begin
            int n_ks = 0;
            @(posedge clk); #1;
            bus.start = 1'b1;
            bus.len   = LEN_W'(2);
            for (int c = 0; c < 40 && n_ks < 4; c++) begin
                @(posedge clk); #1;
                bus.start    = 1'b0;
                bus.ks_valid = 1'b1;
                bus.ks_bit   = ks_q[n_ks];
                bus.pt_valid = 1'b1;
                bus.ct_ready = 1'b1;
                @(negedge clk);
                if (bus.ks_valid && bus.ks_ready) n_ks++;
            end
            check_eq("t5_ks_before_reset", n_ks, 4);
            #2;
            reset = 1'b0;
            #1;
            check_all_zero("t5_async");
            idle_inputs();
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
        end
        fill_random(1);
        run_msg("t5b", 1, 100, 100, 100, 0, 1'b0, 10, 10);

        // T6: second start while busy is ignored
        fill_random(2);
        run_msg("t6", 2, 80, 80, 80, 0, 1'b1, -1, -1);

        // random messages with random flow control
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 5);
            fill_random(len);
            run_msg("rnd", len, $urandom_range(30, 100), $urandom_range(30, 100),
                    $urandom_range(30, 100), 0, 1'b0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
